// File: rtl/snake_pkg.sv
// Shared definitions for the snake frame scheduler: stage codes seen by the
// VGA controller and the scheduler's state encoding.
package snake_pkg;

  localparam logic [1:0] STAGE_IDLE = 2'd0;
  localparam logic [1:0] STAGE_PLAY = 2'd2;
  localparam logic [1:0] STAGE_OVER = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    REQ,
    WAIT_COMMIT,
    OVER
  } state_t;

  // Stage code the display shows for a given scheduler state
  function automatic logic [1:0] stage_of(input state_t s);
    logic [1:0] code;
    code = STAGE_IDLE;
    case (s)
      IDLE:        code = STAGE_IDLE;
      WAIT_FRAME:  code = STAGE_PLAY;
      REQ:         code = STAGE_PLAY;
      WAIT_COMMIT: code = STAGE_PLAY;
      OVER:        code = STAGE_OVER;
      default:     code = STAGE_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/snake_frame_scheduler_frame_tick.sv
// Frame-start detector: flags the first clock on which the active-low
// vertical sync is seen low.
module frame_tick (
  input  logic vga_clk,
  input  logic reset,
  input  logic iVS,
  output logic frame_start
);

  logic vs_q;

  // Previous sync level; resets high so a sync already low at reset release
  // still registers as a frame start
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) vs_q <= 1'b1;
    else       vs_q <= iVS;
  end

  assign frame_start = vs_q & ~iVS;

endmodule

// File: rtl/snake_frame_scheduler.sv
// Paces the snake game to the video frame rate: requests a game step every
// few frames, commits the new snake data only at frame boundaries, and runs
// the stage code and hearts countdown used by the display.
module snake_frame_scheduler
  import snake_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 8,
  parameter int TIMER_FRAMES    = 6,
  parameter int TIMER_MAX       = 100,
  parameter int APPLE_BONUS     = 20
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       iVS,
  input  logic       start,
  input  logic       step_ack,
  input  logic       collision,
  input  logic       apple_eaten,
  output logic       step_req,
  output logic       commit,
  output logic [1:0] stage,
  output logic [6:0] hearts_timer
);

  localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int TCW = (TIMER_FRAMES > 1) ? $clog2(TIMER_FRAMES) : 1;

  logic           frame_start;
  state_t         state_q, state_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TCW-1:0] timer_cnt_q, timer_cnt_d;
  logic [6:0]     hearts_q, hearts_d;
  logic           end_flag_q, end_flag_d;
  logic           step_req_q, step_req_d;
  logic           commit_q, commit_d;
  logic [1:0]     stage_q, stage_d;
  logic           frame_last, timer_last, playing, dec_now, bonus_now;
  logic [7:0]     hearts_sum;

  frame_tick u_frame_tick (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .iVS         (iVS),
    .frame_start (frame_start)
  );

  assign frame_last = (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1));
  assign timer_last = (timer_cnt_q == TCW'(TIMER_FRAMES - 1));
  assign playing    = (state_q == WAIT_FRAME) || (state_q == REQ) || (state_q == WAIT_COMMIT);
  assign dec_now    = playing && frame_start && timer_last;
  assign bonus_now  = (state_q == REQ) && step_ack && apple_eaten;

  // State register
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a commit frame ends the game on a collision or an empty timer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (start) state_d = WAIT_FRAME;
      WAIT_FRAME:  if (frame_start && frame_last) state_d = REQ;
      REQ:         if (step_ack) state_d = WAIT_COMMIT;
      WAIT_COMMIT: if (frame_start) state_d = (end_flag_q || (hearts_q == 7'd0)) ? OVER : WAIT_FRAME;
      OVER:        if (!start) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Output decode, taken from the state being entered so the registered outputs line up with it
  always_comb begin
    step_req_d = (state_d == REQ);
    commit_d   = (state_q == WAIT_COMMIT) && frame_start;
    stage_d    = stage_of(state_d);
  end

  // Frame and timer counters, end flag, and hearts arithmetic (decrement, then bonus, then clamp)
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    timer_cnt_d = timer_cnt_q;
    end_flag_d  = end_flag_q;
    hearts_sum  = {1'b0, hearts_q};

    if (dec_now && (hearts_sum != 8'd0)) hearts_sum = hearts_sum - 8'd1;
    if (bonus_now)                       hearts_sum = hearts_sum + 8'(APPLE_BONUS);
    if (hearts_sum > 8'(TIMER_MAX))      hearts_sum = 8'(TIMER_MAX);
    hearts_d = hearts_q;
    if (playing) hearts_d = hearts_sum[6:0];

    if (playing && frame_start)
      timer_cnt_d = timer_last ? '0 : timer_cnt_q + TCW'(1);

    // The commit frame also counts toward the next step so the steady-state
    // step period stays at FRAMES_PER_STEP frames
    if (frame_start && ((state_q == WAIT_FRAME) || (state_q == WAIT_COMMIT)))
      frame_cnt_d = frame_last ? '0 : frame_cnt_q + FCW'(1);

    if ((state_q == REQ) && step_ack) end_flag_d = collision;

    if ((state_q == IDLE) && start) begin
      frame_cnt_d = '0;
      timer_cnt_d = '0;
      end_flag_d  = 1'b0;
      hearts_d    = 7'(TIMER_MAX);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      timer_cnt_q <= '0;
      hearts_q    <= 7'(TIMER_MAX);
      end_flag_q  <= 1'b0;
      step_req_q  <= 1'b0;
      commit_q    <= 1'b0;
      stage_q     <= STAGE_IDLE;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      timer_cnt_q <= timer_cnt_d;
      hearts_q    <= hearts_d;
      end_flag_q  <= end_flag_d;
      step_req_q  <= step_req_d;
      commit_q    <= commit_d;
      stage_q     <= stage_d;
    end
  end

  assign step_req     = step_req_q;
  assign commit       = commit_q;
  assign stage        = stage_q;
  assign hearts_timer = hearts_q;

endmodule
